// File: rtl/spi_reg_frame_ctrl.sv
// spi_reg_frame_ctrl: frames SPI words into register-bus transactions.
//   A frame starts on the CS falling edge. The first word is a command:
//   bit15 selects read or write, bits14:8 give the start address and
//   bits7:0 give the word count minus one. Writes are issued as reg_wr
//   strobes. Reads are fetched with reg_rd/reg_ack and loaded into the
//   transceiver with tx_load.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   spi_cs_n                raw chip select (async, active low)
//   rx_valid, rx_word       received word strobe and data
//   spi_clk_error           SPI clock lost mid-frame
//   tx_load, tx_word        transceiver load strobe and next word to send
//   reg_wr, reg_rd          register write strobe and read request (level)
//   reg_addr, reg_wdata     register address and write data
//   reg_rdata, reg_ack      register read data, valid in the reg_ack cycle
//   frame_err, busy         frame error pulse and not-idle indication
module spi_reg_frame_ctrl #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_cs_n,
   input  logic        rx_valid,
   input  logic [15:0] rx_word,
   input  logic        spi_clk_error,
   output logic        tx_load,
   output logic [15:0] tx_word,
   output logic        reg_wr,
   output logic        reg_rd,
   output logic [6:0]  reg_addr,
   output logic [15:0] reg_wdata,
   input  logic [15:0] reg_rdata,
   input  logic        reg_ack,
   output logic        frame_err,
   output logic        busy
);

   localparam int unsigned DW     = 16;
   localparam int unsigned AW     = 7;
   localparam int unsigned CW     = 9;
   localparam int unsigned EW     = 8;
   localparam int unsigned WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WR,
      S_RD_FETCH,
      S_RD_STREAM,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic              cs_s1, cs_s2, cs_act_q;
   logic              cs_active, cs_fall, cs_rise;
   logic [AW-1:0]     addr_q, addr_d;
   logic [CW-1:0]     rem_q, rem_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [EW-1:0]     err_cnt_q, err_cnt_d;
   logic              reg_rd_q, reg_rd_d;
   logic              tx_load_d, reg_wr_d, frame_err_d;
   logic [DW-1:0]     tx_word_d, reg_wdata_d;
   logic [AW-1:0]     reg_addr_d;
   logic              active_d;

   // Two-flop CS synchroniser; reset to the inactive (high) level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_s1    <= 1'b1;
         cs_s2    <= 1'b1;
         cs_act_q <= 1'b0;
      end else begin
         cs_s1    <= spi_cs_n;
         cs_s2    <= cs_s1;
         cs_act_q <= cs_active;
      end
   end

   assign cs_active = ~cs_s2;
   assign cs_fall   = cs_active & ~cs_act_q;
   assign cs_rise   = ~cs_active & cs_act_q;

   // A lost SPI clock must release the bus request in the same cycle
   assign reg_rd = reg_rd_q & ~spi_clk_error;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         wait_q    <= '0;
         err_cnt_q <= '0;
         reg_rd_q  <= 1'b0;
         tx_load   <= 1'b0;
         tx_word   <= '0;
         reg_wr    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         wait_q    <= wait_d;
         err_cnt_q <= err_cnt_d;
         reg_rd_q  <= reg_rd_d;
         tx_load   <= tx_load_d;
         tx_word   <= tx_word_d;
         reg_wr    <= reg_wr_d;
         reg_addr  <= reg_addr_d;
         reg_wdata <= reg_wdata_d;
         frame_err <= frame_err_d;
         busy      <= (state_d != S_IDLE);
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      wait_d      = wait_q;
      reg_rd_d    = 1'b0;
      tx_load_d   = 1'b0;
      tx_word_d   = tx_word;
      reg_wr_d    = 1'b0;
      reg_addr_d  = reg_addr;
      reg_wdata_d = reg_wdata;
      frame_err_d = 1'b0;
      active_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cs_fall) begin
               tx_word_d = {8'h5A, err_cnt_q};
               tx_load_d = 1'b1;
               state_d   = S_CMD;
            end
         end
         S_CMD: begin
            if (rx_valid) begin
               addr_d = rx_word[14:8];
               rem_d  = CW'(rx_word[7:0]) + CW'(1);
               if (rx_word[15]) begin
                  reg_rd_d   = 1'b1;
                  reg_addr_d = rx_word[14:8];
                  wait_d     = '0;
                  state_d    = S_RD_FETCH;
               end else begin
                  state_d = S_WR;
               end
            end
         end
         S_WR: begin
            if (rx_valid) begin
               reg_wr_d    = 1'b1;
               reg_addr_d  = addr_q;
               reg_wdata_d = rx_word;
               addr_d      = addr_q + AW'(1);
               rem_d       = rem_q - CW'(1);
               if (rem_q == CW'(1)) state_d = S_DONE;
            end
         end
         S_RD_FETCH: begin
            if (reg_ack) begin
               tx_word_d = reg_rdata;
               tx_load_d = 1'b1;
               state_d   = S_RD_STREAM;
            end else if (wait_q == WAIT_LAST) begin
               tx_word_d   = 16'hDEAD;
               tx_load_d   = 1'b1;
               frame_err_d = 1'b1;
               state_d     = S_ERR;
            end else begin
               reg_rd_d = 1'b1;
               wait_d   = wait_q + WAIT_W'(1);
            end
         end
         S_RD_STREAM: begin
            if (rx_valid) begin
               rem_d = rem_q - CW'(1);
               if (rem_q != CW'(1)) begin
                  addr_d     = addr_q + AW'(1);
                  reg_addr_d = addr_q + AW'(1);
                  reg_rd_d   = 1'b1;
                  wait_d     = '0;
                  state_d    = S_RD_FETCH;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: ;
         S_ERR:  ;
         default: state_d = S_IDLE;
      endcase

      // Lost SPI clock aborts any frame still in progress
      if (spi_clk_error && (state_q inside {S_CMD, S_WR, S_RD_FETCH, S_RD_STREAM})) begin
         state_d     = S_ERR;
         reg_rd_d    = 1'b0;
         reg_wr_d    = 1'b0;
         tx_load_d   = 1'b0;
         tx_word_d   = tx_word;
         frame_err_d = 1'b1;
      end

      // CS release ends the frame; a coincident word has already been
      // applied above, so any state still mid-transfer is a short frame
      if (cs_rise) begin
         active_d  = state_d inside {S_CMD, S_WR, S_RD_FETCH, S_RD_STREAM};
         state_d   = S_IDLE;
         reg_rd_d  = 1'b0;
         tx_load_d = 1'b0;
         if (active_d) frame_err_d = 1'b1;
      end

      err_cnt_d = err_cnt_q;
      if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + EW'(1);
   end

endmodule

// File: tb/tb_spi_reg_frame_ctrl.sv
// Directed bench for spi_reg_frame_ctrl: write burst, wrapping read,
// ack timeout, short frame, CS release with a coincident word, lost SPI
// clock and reset mid-frame.
module tb_spi_reg_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        rx_valid = 1'b0;
   logic [15:0] rx_word = '0;
   logic        spi_clk_error = 1'b0;
   logic        tx_load;
   logic [15:0] tx_word;
   logic        reg_wr;
   logic        reg_rd;
   logic [6:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic [15:0] reg_rdata = '0;
   logic        reg_ack = 1'b0;
   logic        frame_err;
   logic        busy;

   spi_reg_frame_ctrl #(.ACK_TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n),
      .rx_valid(rx_valid), .rx_word(rx_word), .spi_clk_error(spi_clk_error),
      .tx_load(tx_load), .tx_word(tx_word),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Event log collected on the falling edge
   logic [31:0] wr_q[$];
   logic [15:0] tx_q[$];
   logic [6:0]  rd_q[$];
   int          ferr_cnt = 0;
   int          rd_hi = 0;
   logic        rd_prev = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         rd_prev = 1'b0;
      end else begin
         if (reg_wr)  wr_q.push_back({9'd0, reg_addr, reg_wdata});
         if (tx_load) tx_q.push_back(tx_word);
         if (frame_err) ferr_cnt++;
         if (reg_rd) rd_hi++;
         if (reg_rd && !rd_prev) rd_q.push_back(reg_addr);
         rd_prev = reg_rd;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [15:0] w);
      rx_word  = w;
      rx_valid = 1'b1;
      step(1);
      rx_valid = 1'b0;
   endtask

   task automatic cs_open(input string tag, input logic [15:0] status);
      spi_cs_n = 1'b0;
      step(6);
      check({tag, "_status_n"}, 32'(tx_q.size()), 32'd1);
      check({tag, "_status"}, 32'(tx_q[0]), 32'(status));
      tx_q.delete();
   endtask

   task automatic cs_close;
      spi_cs_n = 1'b1;
      step(6);
   endtask

   task automatic ack_read(input logic [15:0] data);
      int n = 0;
      while (!reg_rd && n < 20) begin
         step(1);
         n++;
      end
      check("rd_req_seen", 32'(reg_rd), 32'd1);
      step(3);
      reg_ack   = 1'b1;
      reg_rdata = data;
      step(1);
      reg_ack   = 1'b0;
      reg_rdata = '0;
   endtask

   int f0;
   int r0;

   initial begin
      // Reset state
      step(3);
      check("rst_flags", 32'({tx_load, reg_wr, reg_rd, frame_err, busy}), 32'd0);
      check("rst_bus", {9'd0, reg_addr, reg_wdata}, 32'd0);
      check("rst_txw", 32'(tx_word), 32'd0);
      rst_n = 1'b1;
      step(4);

      // Write burst 12..14
      cs_open("wr", 16'h5A00);
      check("wr_busy_cmd", 32'(busy), 32'd1);
      send(16'h1202); step(8);
      send(16'h1111); step(8);
      send(16'h2222); step(8);
      send(16'h3333); step(8);
      send(16'h4444); step(8);
      check("wr_n", 32'(wr_q.size()), 32'd3);
      check("wr_0", wr_q[0], 32'h0012_1111);
      check("wr_1", wr_q[1], 32'h0013_2222);
      check("wr_2", wr_q[2], 32'h0014_3333);
      check("wr_done_busy", 32'(busy), 32'd1);
      check("wr_no_tx", 32'(tx_q.size()), 32'd0);
      wr_q.delete();
      cs_close();
      check("wr_idle", 32'(busy), 32'd0);
      check("wr_ferr", 32'(ferr_cnt), 32'd0);

      // Read with address wrap 7F -> 00
      rd_hi = 0;
      cs_open("rd", 16'h5A00);
      send(16'hFF01);
      ack_read(16'hAAAA); step(4);
      send(16'h0000);
      ack_read(16'hBBBB); step(4);
      send(16'h0000); step(4);
      check("rd_n", 32'(rd_q.size()), 32'd2);
      check("rd_a0", 32'(rd_q[0]), 32'h7F);
      check("rd_a1", 32'(rd_q[1]), 32'h00);
      check("rd_tx_n", 32'(tx_q.size()), 32'd2);
      check("rd_tx0", 32'(tx_q[0]), 32'hAAAA);
      check("rd_tx1", 32'(tx_q[1]), 32'hBBBB);
      check("rd_level", 32'(rd_hi), 32'd8);
      check("rd_done_busy", 32'(busy), 32'd1);
      rd_q.delete(); tx_q.delete();
      cs_close();
      check("rd_ferr", 32'(ferr_cnt), 32'd0);
      check("rd_idle", 32'(busy), 32'd0);

      // Ack timeout
      cs_open("to", 16'h5A00);
      r0 = rd_hi;
      send(16'h8005);
      step(300);
      check("to_rd_cycles", 32'(rd_hi - r0), 32'd255);
      check("to_tx_n", 32'(tx_q.size()), 32'd1);
      check("to_dead", 32'(tx_q[0]), 32'hDEAD);
      check("to_ferr", 32'(ferr_cnt), 32'd1);
      check("to_err_busy", 32'(busy), 32'd1);
      tx_q.delete(); rd_q.delete();
      reg_ack = 1'b1; reg_rdata = 16'h1234; step(1); reg_ack = 1'b0;
      send(16'h0000); step(4);
      check("to_err_quiet", 32'(tx_q.size()), 32'd0);
      cs_close();
      check("to_ferr_once", 32'(ferr_cnt), 32'd1);

      // Short write frame: 2 of 4 words
      cs_open("sh", 16'h5A01);
      send(16'h0003); step(8);
      send(16'hAAA1); step(8);
      send(16'hAAA2); step(8);
      cs_close();
      check("sh_n", 32'(wr_q.size()), 32'd2);
      check("sh_0", wr_q[0], 32'h0000_AAA1);
      check("sh_1", wr_q[1], 32'h0001_AAA2);
      check("sh_ferr", 32'(ferr_cnt), 32'd2);
      check("sh_idle", 32'(busy), 32'd0);
      wr_q.delete();

      // Last word arrives together with CS release: complete, no error
      cs_open("co", 16'h5A02);
      send(16'h0501); step(8);
      send(16'h1234); step(8);
      spi_cs_n = 1'b1;
      step(2);
      send(16'h5678); step(6);
      check("co_n", 32'(wr_q.size()), 32'd2);
      check("co_1", wr_q[1], 32'h0006_5678);
      check("co_ferr", 32'(ferr_cnt), 32'd2);
      check("co_idle", 32'(busy), 32'd0);
      wr_q.delete();

      // Lost SPI clock while fetching
      cs_open("ce", 16'h5A02);
      f0 = ferr_cnt;
      send(16'h8A02);
      step(1);
      check("ce_rd_before", 32'(reg_rd), 32'd1);
      spi_clk_error = 1'b1;
      #1;
      check("ce_rd_same", 32'(reg_rd), 32'd0);
      step(1);
      spi_clk_error = 1'b0;
      reg_ack = 1'b1; reg_rdata = 16'h9999; step(1); reg_ack = 1'b0;
      send(16'h0000); step(4);
      check("ce_ferr", 32'(ferr_cnt - f0), 32'd1);
      check("ce_quiet", 32'(tx_q.size()), 32'd0);
      check("ce_rd_low", 32'(reg_rd), 32'd0);
      check("ce_busy", 32'(busy), 32'd1);
      cs_close();
      check("ce_ferr_once", 32'(ferr_cnt - f0), 32'd1);
      check("ce_idle", 32'(busy), 32'd0);
      rd_q.delete(); tx_q.delete();

      // Reset in the middle of a write burst
      cs_open("rs", 16'h5A03);
      send(16'h0203); step(8);
      send(16'h0BEE); step(3);
      check("rs_pre_wr", wr_q[0], 32'h0002_0BEE);
      wr_q.delete();
      rst_n = 1'b0;
      #1;
      check("rs_flags", 32'({tx_load, reg_wr, reg_rd, frame_err, busy}), 32'd0);
      check("rs_bus", {9'd0, reg_addr, reg_wdata}, 32'd0);
      check("rs_txw", 32'(tx_word), 32'd0);
      step(2);
      spi_cs_n = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(4);
      send(16'h0C0C); step(4);
      check("rs_no_wr", 32'(wr_q.size()), 32'd0);
      check("rs_idle", 32'(busy), 32'd0);
      cs_open("rs2", 16'h5A00);
      send(16'h0300); step(8);
      send(16'h7777); step(8);
      check("rs2_n", 32'(wr_q.size()), 32'd1);
      check("rs2_0", wr_q[0], 32'h0003_7777);
      check("rs2_done", 32'(busy), 32'd1);
      cs_close();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
